// File: rtl/toggle_cover_pkg.sv
// Shared types and helpers for the toggle-coverage collector.
// Cover point p = 2*bit + dir, offset by the instance's global base index.
package toggle_cover_pkg;

   localparam logic DIR_RISE = 1'b0;
   localparam logic DIR_FALL = 1'b1;

   // Widest vector popcount() accepts; wider callers are truncated.
   localparam int unsigned POP_MAX_W = 256;

   typedef enum logic {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

   function automatic int unsigned point_index(input int unsigned base,
                                               input int unsigned bit_pos,
                                               input logic        dir);
      return base + 2 * bit_pos + {31'b0, dir};
   endfunction

   function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/toggle_cover_prienc.sv
// Lowest-set-bit priority encoder over the interleaved pend vector.
module toggle_cover_prienc #(
   parameter  int unsigned N  = 72,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  vec_i,
   output logic          found_o,
   output logic [IW-1:0] idx_o
);

   always_comb begin
      found_o = 1'b0;
      idx_o   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            found_o = 1'b1;
            idx_o   = IW'(i);
         end
      end
   end

endmodule

// File: rtl/toggle_cover_collector.sv
// Toggle-coverage producer: first-hit detection per bit/direction, each newly
// covered point emitted once as a global index on a valid/ready stream.
module toggle_cover_collector
   import toggle_cover_pkg::*;
#(
   parameter int unsigned WIDTH       = 36,
   parameter int unsigned COVER_INDEX = 0,
   parameter int unsigned IDX_W       = 32,
   parameter int unsigned CNT_W       = $clog2(2 * WIDTH + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic             clear,
   input  logic [WIDTH-1:0] sig_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_rise,
   output logic [CNT_W-1:0] hit_count
);

   localparam int unsigned NPTS = 2 * WIDTH;
   localparam int unsigned PW   = (NPTS > 1) ? $clog2(NPTS) : 1;

   state_e state_q, state_d;
   logic   prime_c, run_c;

   logic [WIDTH-1:0] prev_q, prev_d;
   logic             primed_q, primed_d;
   logic [WIDTH-1:0] rise_hit_q, rise_hit_d, fall_hit_q, fall_hit_d;
   logic [WIDTH-1:0] rise_pend_q, rise_pend_d, fall_pend_q, fall_pend_d;
   logic             out_valid_q, out_valid_d;
   logic [IDX_W-1:0] out_index_q, out_index_d;
   logic             out_rise_q, out_rise_d;
   logic [CNT_W-1:0] hit_count_q, hit_count_d;

   logic             detect_c, load_c;
   logic [WIDTH-1:0] rise_new_c, fall_new_c;
   logic [NPTS-1:0]  pend_vec_c, sel_mask_c;
   logic             sel_found_c;
   logic [PW-1:0]    sel_idx_c;

   // State register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_PRIME;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_PRIME: state_d = ST_RUN;
         ST_RUN:   state_d = ST_RUN;
         default:  state_d = ST_PRIME;
      endcase
   end

   always_comb begin
      prime_c = 1'b0;
      run_c   = 1'b0;
      case (state_q)
         ST_PRIME: prime_c = 1'b1;
         ST_RUN:   run_c   = 1'b1;
         default:  prime_c = 1'b1;
      endcase
   end

   // Interleave pend maps so point order is bit-major with rise before fall.
   always_comb begin
      pend_vec_c = '0;
      for (int b = 0; b < WIDTH; b++) begin
         pend_vec_c[2 * b + 32'(DIR_RISE)] = rise_pend_q[b];
         pend_vec_c[2 * b + 32'(DIR_FALL)] = fall_pend_q[b];
      end
   end

   toggle_cover_prienc #(
      .N (NPTS)
   ) u_prienc (
      .vec_i   (pend_vec_c),
      .found_o (sel_found_c),
      .idx_o   (sel_idx_c)
   );

   always_comb begin
      prev_d      = sig_in;
      primed_d    = primed_q | prime_c;
      detect_c    = run_c & primed_q & enable & ~clear;
      rise_new_c  = detect_c ? (~prev_q & sig_in & ~rise_hit_q) : '0;
      fall_new_c  = detect_c ? (prev_q & ~sig_in & ~fall_hit_q) : '0;
      load_c      = ~out_valid_q | out_ready;
      sel_mask_c  = (load_c & sel_found_c) ? (NPTS'(1) << sel_idx_c) : '0;

      out_valid_d = out_valid_q;
      out_index_d = out_index_q;
      out_rise_d  = out_rise_q;
      if (load_c) begin
         out_valid_d = sel_found_c;
         if (sel_found_c) begin
            out_index_d = IDX_W'(point_index(COVER_INDEX, 32'(sel_idx_c >> 1),
                                             sel_idx_c[0]));
            out_rise_d  = (sel_idx_c[0] == DIR_RISE);
         end
      end

      // The selected point was already hit, so it can never be re-pended here.
      rise_pend_d = rise_pend_q | rise_new_c;
      fall_pend_d = fall_pend_q | fall_new_c;
      for (int b = 0; b < WIDTH; b++) begin
         if (sel_mask_c[2 * b + 32'(DIR_RISE)]) rise_pend_d[b] = 1'b0;
         if (sel_mask_c[2 * b + 32'(DIR_FALL)]) fall_pend_d[b] = 1'b0;
      end
      rise_hit_d  = rise_hit_q | rise_new_c;
      fall_hit_d  = fall_hit_q | fall_new_c;
      hit_count_d = hit_count_q
                  + CNT_W'(popcount(POP_MAX_W'({fall_new_c, rise_new_c})));

      if (clear) begin
         rise_hit_d  = '0;
         fall_hit_d  = '0;
         rise_pend_d = '0;
         fall_pend_d = '0;
         hit_count_d = '0;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prev_q      <= '0;
         primed_q    <= 1'b0;
         rise_hit_q  <= '0;
         fall_hit_q  <= '0;
         rise_pend_q <= '0;
         fall_pend_q <= '0;
         out_valid_q <= 1'b0;
         out_index_q <= '0;
         out_rise_q  <= 1'b0;
         hit_count_q <= '0;
      end else begin
         prev_q      <= prev_d;
         primed_q    <= primed_d;
         rise_hit_q  <= rise_hit_d;
         fall_hit_q  <= fall_hit_d;
         rise_pend_q <= rise_pend_d;
         fall_pend_q <= fall_pend_d;
         out_valid_q <= out_valid_d;
         out_index_q <= out_index_d;
         out_rise_q  <= out_rise_d;
         hit_count_q <= hit_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_index = out_index_q;
   assign out_rise  = out_rise_q;
   assign hit_count = hit_count_q;

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Bench for toggle_cover_collector: two instances (base 0 and base 100) on the
// same stimulus, a point-level reference model, and directed literal checks.
module tb_toggle_cover_collector;

   localparam int W    = 36;
   localparam int NP   = 2 * W;
   localparam int BASE = 100;

   logic          clock = 1'b0;
   logic          reset, enable, clear, out_ready;
   logic [W-1:0]  sig_in;
   logic          v0, v1, r0, r1;
   logic [31:0]   i0, i1;
   logic [6:0]    c0, c1;

   int n_pass  = 0;
   int n_total = 0;
   int cyc     = 0;

   int em0[$];
   int em1[$];
   int er0[$];
   int fc[$];

   // Reference model state, in terms of cover points
   bit           m_run;
   logic [W-1:0] m_prev;
   bit           m_hit[NP];
   bit           m_pend[NP];
   int           m_count, m_idx;
   bit           m_valid;

   toggle_cover_collector #(.WIDTH(W), .COVER_INDEX(0)) dut0 (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .sig_in(sig_in), .out_valid(v0), .out_ready(out_ready),
      .out_index(i0), .out_rise(r0), .hit_count(c0));

   toggle_cover_collector #(.WIDTH(W), .COVER_INDEX(BASE)) dut1 (
      .clock(clock), .reset(reset), .enable(enable), .clear(clear),
      .sig_in(sig_in), .out_valid(v1), .out_ready(out_ready),
      .out_index(i1), .out_rise(r1), .hit_count(c1));

   always #5 clock = ~clock;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic do_reset();
      reset = 1'b1; sig_in = '0; clear = 1'b0; enable = 1'b1; out_ready = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(1);
      em0.delete(); em1.delete(); er0.delete(); fc.delete();
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Record accepted indices (values sampled before the edge updates them)
   always @(posedge clock) begin
      if (!reset && v0 && out_ready) begin
         em0.push_back(int'(i0));
         er0.push_back(int'(r0));
         fc.push_back(cyc);
      end
      if (!reset && v1 && out_ready) em1.push_back(int'(i1));
   end

   // Reference model: first-hit tracking per point, lowest pending point out
   always @(posedge clock) begin
      if (reset) begin
         m_run = 0; m_prev = '0; m_valid = 0; m_idx = 0; m_count = 0;
         for (int p = 0; p < NP; p++) begin m_hit[p] = 0; m_pend[p] = 0; end
      end else begin
         if (clear) begin
            for (int p = 0; p < NP; p++) begin m_hit[p] = 0; m_pend[p] = 0; end
            m_count = 0;
            m_valid = 0;
         end else begin
            if (!m_valid || out_ready) begin
               m_valid = 0;
               for (int p = 0; p < NP; p++) begin
                  if (m_pend[p]) begin
                     m_valid = 1; m_idx = p; m_pend[p] = 0;
                     break;
                  end
               end
            end
            if (m_run && enable) begin
               for (int b = 0; b < W; b++) begin
                  if (!m_prev[b] && sig_in[b] && !m_hit[2*b]) begin
                     m_hit[2*b] = 1; m_pend[2*b] = 1; m_count++;
                  end
                  if (m_prev[b] && !sig_in[b] && !m_hit[2*b+1]) begin
                     m_hit[2*b+1] = 1; m_pend[2*b+1] = 1; m_count++;
                  end
               end
            end
         end
         m_run  = 1;
         m_prev = sig_in;
      end
   end

   // Per-cycle comparison against the model
   always @(posedge clock) begin
      #1;
      check("valid0", v0, m_valid);
      check("valid1", v1, m_valid);
      check("count0", c0, m_count);
      check("count1", c1, m_count);
      if (m_valid) begin
         check("index0", i0, m_idx);
         check("index1", i1, m_idx + BASE);
         check("rise0", r0, (m_idx % 2) == 0);
         check("rise1", r1, (m_idx % 2) == 0);
      end
   end

   initial begin
      int bad;
      reset = 1'b1; enable = 1'b1; clear = 1'b0; out_ready = 1'b1; sig_in = '0;
      tick(2);
      check("rst_valid", v0, 0);
      check("rst_index", i0, 0);
      check("rst_rise", r0, 0);
      check("rst_count", c0, 0);

      // Prime: 0 captured, then 0->1 on bit 0
      reset = 1'b0;
      tick(1);
      check("prime_no_out", v0, 0);
      sig_in = 36'h1;
      tick(1);
      check("prime_count_now", c0, 1);
      tick(4);
      check("prime_n_out", em0.size(), 1);
      check("prime_idx", (em0.size() > 0) ? em0[0] : -1, 0);
      check("prime_rise", (er0.size() > 0) ? er0[0] : -1, 1);
      check("prime_count", c0, 1);

      // Repeat suppression on bit 5
      do_reset();
      sig_in = 36'h20; tick(1);
      sig_in = 36'h00; tick(1);
      sig_in = 36'h20; tick(6);
      check("rep_n_out", em1.size(), 2);
      check("rep_idx0", (em1.size() > 0) ? em1[0] : -1, 110);
      check("rep_idx1", (em1.size() > 1) ? em1[1] : -1, 111);
      check("rep_dir0", (er0.size() > 0) ? er0[0] : -1, 1);
      check("rep_dir1", (er0.size() > 1) ? er0[1] : -1, 0);
      check("rep_count", c1, 2);

      // Backpressure: bits 0 and 3 rise together, sink stalls 4 cycles
      do_reset();
      out_ready = 1'b0;
      sig_in = 36'h9;
      tick(1);
      check("bp_count_now", c0, 2);
      check("bp_no_out_yet", v0, 0);
      for (int k = 0; k < 4; k++) begin
         tick(1);
         check("bp_hold_valid", v0, 1);
         check("bp_hold_idx", i0, 0);
      end
      out_ready = 1'b1;
      tick(1);
      check("bp_next_valid", v0, 1);
      check("bp_next_idx", i0, 6);
      tick(1);
      check("bp_drained", v0, 0);
      check("bp_n_out", em0.size(), 2);

      // Full sweep 0 -> ones -> 0
      do_reset();
      sig_in = '1; tick(1);
      sig_in = '0; tick(81);
      check("sweep_n_out", em0.size(), 72);
      bad = 0;
      for (int k = 0; k < em0.size(); k++) if (em0[k] != k) bad++;
      check("sweep_order_errs", bad, 0);
      check("sweep_span", (fc.size() == 72) ? fc[71] - fc[0] : -1, 71);
      check("sweep_count", c0, 72);

      // Clear in the same cycle bit 2 rises
      do_reset();
      sig_in = 36'h4; clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("clr_valid", v0, 0);
      check("clr_count", c0, 0);
      tick(3);
      check("clr_still_idle", em0.size(), 0);
      sig_in = 36'h0;
      tick(5);
      check("clr_n_out", em0.size(), 1);
      check("clr_idx", (em0.size() > 0) ? em0[0] : -1, 5);
      check("clr_count_after", c0, 1);

      // Enable low, then reset with 3 points pending
      do_reset();
      enable = 1'b0;
      sig_in = 36'h2; tick(1);
      sig_in = 36'h0; tick(4);
      check("en_n_out", em0.size(), 0);
      check("en_count", c0, 0);
      enable = 1'b1; out_ready = 1'b0;
      sig_in = 36'h7; tick(1);
      check("en_count3", c0, 3);
      tick(1);
      check("en_held", v0, 1);
      reset = 1'b1; tick(1);
      check("mid_rst_valid", v0, 0);
      check("mid_rst_index", i0, 0);
      check("mid_rst_rise", r0, 0);
      check("mid_rst_count", c0, 0);
      reset = 1'b0; out_ready = 1'b1;
      tick(6);
      check("post_rst_n_out", em0.size(), 0);
      check("post_rst_count", c0, 0);
      sig_in = 36'h5; tick(4);
      check("post_rst_new_n", em0.size(), 1);
      check("post_rst_new_idx", (em0.size() > 0) ? em0[0] : -1, 3);
      check("post_rst_new_cnt", c0, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
